router_pkt_fsm: RTL and testbench

- Input-side packet controller for the 1x3 router.
- Sequences the header/payload/parity register and the write-enable synchroniser over each packet: decodes the destination, stalls on full/non-empty FIFOs, and drives the load-phase strobes.
- Sits between the input port and router_reg/router_sync inside router_top.

---
 rtl/router_pkg.sv | 20 ++
 rtl/router_wait_timer.sv | 39 +++
 rtl/router_pkt_fsm.sv | 157 +++++++++++++++
 tb/tb_router_pkt_fsm.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and defaults for the 1x3 router input-side controller.
package router_pkg;

  localparam int NUM_PORTS_DEF = 3;
  localparam int ADDR_W_DEF    = 2;
  localparam int WAIT_MAX_DEF  = 30;
  localparam logic [1:0] INVALID_ADDR = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    LOAD_PARITY,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    WAIT_TILL_EMPTY,
    CHECK_PARITY_ERROR
  } fsm_state_e;

endpackage

// File: rtl/router_wait_timer.sv
// Cycle counter for the WAIT_TILL_EMPTY dwell; present only with ROUTER_PKT_FSM_TIMEOUT_EN.
// Counts while run_i is high, held at zero otherwise; tc_o flags the last allowed wait cycle.
`ifdef ROUTER_PKT_FSM_TIMEOUT_EN
module router_wait_timer #(
  parameter int WAIT_MAX = 30
) (
  input  logic clock,
  input  logic reset,
  input  logic run_i,
  output logic tc_o
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_MAX);
  localparam logic [CW-1:0] TC_VAL  = CW'(WAIT_MAX - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = '0;
    if (run_i) begin
      count_d = (count_q == CNT_MAX) ? count_q : count_q + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The cycle in which the count equals WAIT_MAX-1 is the WAIT_MAX-th cycle in the wait state.
  assign tc_o = run_i && (count_q == TC_VAL);

endmodule
`endif

// File: rtl/router_pkt_fsm.sv
// Input-side packet controller for the 1x3 router: header decode, load-phase strobes, stalls.
// Optional wait timeout with drop pulse enabled by ROUTER_PKT_FSM_TIMEOUT_EN.
//
// state              | meaning
// DECODE_ADDRESS     | idle, waiting for a header with a valid destination
// LOAD_FIRST_DATA    | header byte written into the FIFO
// LOAD_DATA          | payload bytes streaming
// LOAD_PARITY        | parity byte written after pkt_valid fell
// FIFO_FULL_STATE    | stalled on a full destination FIFO
// LOAD_AFTER_FULL    | byte held during the stall is written
// WAIT_TILL_EMPTY    | destination FIFO still draining a previous packet
// CHECK_PARITY_ERROR | internal parity state cleared
module router_pkt_fsm
  import router_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
`ifdef ROUTER_PKT_FSM_TIMEOUT_EN
  ,
  parameter int WAIT_MAX  = WAIT_MAX_DEF
`endif
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 write_enb_reg,
  output logic                 rst_int_reg,
  output logic                 busy,
  output logic [ADDR_W-1:0]    cur_addr,
  output logic                 pkt_drop
);

  localparam int NSLOT = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] NUM_PORTS_W = (ADDR_W + 1)'(NUM_PORTS);

  fsm_state_e        state_q;
  logic [ADDR_W-1:0] cur_addr_q;

  logic [NSLOT-1:0] empty_ext;
  logic [NSLOT-1:0] srst_ext;
  logic             addr_ok;
  logic             hdr_empty;
  logic             sel_empty;
  logic             sel_srst;

  // Pad the per-port flags to the full address space so unused addresses index safely.
  always_comb begin
    empty_ext = '0;
    srst_ext  = '0;
    empty_ext[NUM_PORTS-1:0] = fifo_empty;
    srst_ext[NUM_PORTS-1:0]  = soft_reset;
  end

  assign addr_ok   = {1'b0, data_in} < NUM_PORTS_W;
  assign hdr_empty = empty_ext[data_in];
  assign sel_empty = empty_ext[cur_addr_q];
  assign sel_srst  = srst_ext[cur_addr_q];

`ifdef ROUTER_PKT_FSM_TIMEOUT_EN
  logic wait_tc;
  logic pkt_drop_q;

  router_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clock (clock),
    .reset (reset),
    .run_i (state_q == WAIT_TILL_EMPTY),
    .tc_o  (wait_tc)
  );
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= DECODE_ADDRESS;
      cur_addr_q <= '0;
`ifdef ROUTER_PKT_FSM_TIMEOUT_EN
      pkt_drop_q <= 1'b0;
`endif
    end else begin
`ifdef ROUTER_PKT_FSM_TIMEOUT_EN
      pkt_drop_q <= 1'b0;
`endif
      // A flush of the selected FIFO abandons the packet from any active state.
      if ((state_q != DECODE_ADDRESS) && sel_srst) begin
        state_q <= DECODE_ADDRESS;
      end else begin
        case (state_q)
          DECODE_ADDRESS: begin
            if (pkt_valid && addr_ok) begin
              cur_addr_q <= data_in;
              state_q    <= hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
          end
          LOAD_FIRST_DATA: state_q <= LOAD_DATA;
          LOAD_DATA: begin
            if (fifo_full)       state_q <= FIFO_FULL_STATE;
            else if (!pkt_valid) state_q <= LOAD_PARITY;
          end
          FIFO_FULL_STATE: begin
            if (!fifo_full) state_q <= LOAD_AFTER_FULL;
          end
          LOAD_AFTER_FULL: begin
            if (parity_done)        state_q <= DECODE_ADDRESS;
            else if (low_pkt_valid) state_q <= LOAD_PARITY;
            else                    state_q <= LOAD_DATA;
          end
          LOAD_PARITY: state_q <= CHECK_PARITY_ERROR;
          CHECK_PARITY_ERROR: begin
            state_q <= fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
          end
          WAIT_TILL_EMPTY: begin
            if (sel_empty) begin
              state_q <= LOAD_FIRST_DATA;
`ifdef ROUTER_PKT_FSM_TIMEOUT_EN
            end else if (wait_tc) begin
              state_q    <= DECODE_ADDRESS;
              pkt_drop_q <= 1'b1;
`endif
            end
          end
          default: state_q <= DECODE_ADDRESS;
        endcase
      end
    end
  end

  assign detect_add    = (state_q == DECODE_ADDRESS);
  assign lfd_state     = (state_q == LOAD_FIRST_DATA);
  assign ld_state      = (state_q == LOAD_DATA);
  assign laf_state     = (state_q == LOAD_AFTER_FULL);
  assign full_state    = (state_q == FIFO_FULL_STATE);
  assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
  assign write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_AFTER_FULL) ||
                         (state_q == LOAD_PARITY);
  // Only the idle and streaming phases accept new bytes from the source.
  assign busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));
  assign cur_addr      = cur_addr_q;

`ifdef ROUTER_PKT_FSM_TIMEOUT_EN
  assign pkt_drop = pkt_drop_q;
`else
  assign pkt_drop = 1'b0;
`endif

endmodule

// File: tb/tb_router_pkt_fsm.sv
// Self-checking bench for router_pkt_fsm: directed vector table, corner sequences, random vs model.
module tb_router_pkt_fsm;
  import router_pkg::*;

  localparam int NP = 3;
  localparam int WM = 30;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pkt_valid = 1'b0;
  logic [1:0] data_in = '0;
  logic       fifo_full = 1'b0;
  logic [2:0] fifo_empty = '0;
  logic [2:0] soft_reset = '0;
  logic       parity_done = 1'b0;
  logic       low_pkt_valid = 1'b0;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy, pkt_drop;
  logic [1:0] cur_addr;
  logic [7:0] dut_out;

  always #5 clock = ~clock;

  router_pkt_fsm dut (
    .clock         (clock),
    .reset         (reset),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .soft_reset    (soft_reset),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .write_enb_reg (write_enb_reg),
    .rst_int_reg   (rst_int_reg),
    .busy          (busy),
    .cur_addr      (cur_addr),
    .pkt_drop      (pkt_drop)
  );

  // {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
  assign dut_out = {detect_add, lfd_state, ld_state, laf_state, full_state,
                    write_enb_reg, rst_int_reg, busy};

  localparam logic [7:0] O_DEC  = 8'h80;
  localparam logic [7:0] O_LFD  = 8'h41;
  localparam logic [7:0] O_LD   = 8'h24;
  localparam logic [7:0] O_LAF  = 8'h15;
  localparam logic [7:0] O_FULL = 8'h09;
  localparam logic [7:0] O_LP   = 8'h05;
  localparam logic [7:0] O_CPE  = 8'h03;
  localparam logic [7:0] O_WAIT = 8'h01;

  int checks = 0;
  int errors = 0;

  // Packet-phase reference model
  localparam int PH_IDLE = 0, PH_HDR = 1, PH_PAY = 2, PH_FULL = 3;
  localparam int PH_AFTER = 4, PH_PAR = 5, PH_CHK = 6, PH_WAIT = 7;
  int         m_ph;
  int         m_wait;
  logic [1:0] m_addr;
  logic       m_drop;

  typedef struct {
    logic       pv;
    logic [1:0] din;
    logic       ff;
    logic [2:0] fe;
    logic [2:0] sr;
    logic       pd;
    logic       lpv;
    logic [7:0] exp_o;
    logic [1:0] exp_a;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic pv, input logic [1:0] din, input logic ff,
                              input logic [2:0] fe, input logic [2:0] sr, input logic pd,
                              input logic lpv, input logic [7:0] exp_o, input logic [1:0] exp_a);
    vec_t v;
    v.pv = pv; v.din = din; v.ff = ff; v.fe = fe; v.sr = sr; v.pd = pd; v.lpv = lpv;
    v.exp_o = exp_o; v.exp_a = exp_a;
    return v;
  endfunction

  function automatic logic [7:0] phase_outputs(input int ph);
    logic [7:0] o;
    o[7] = (ph == PH_IDLE);
    o[6] = (ph == PH_HDR);
    o[5] = (ph == PH_PAY);
    o[4] = (ph == PH_AFTER);
    o[3] = (ph == PH_FULL);
    o[2] = (ph == PH_PAY) || (ph == PH_AFTER) || (ph == PH_PAR);
    o[1] = (ph == PH_CHK);
    o[0] = !((ph == PH_IDLE) || (ph == PH_PAY));
    return o;
  endfunction

  task automatic check(input string name, input logic [7:0] exp_o, input logic [1:0] exp_a,
                       input logic exp_d);
    checks++;
    if (dut_out !== exp_o || cur_addr !== exp_a || pkt_drop !== exp_d) begin
      errors++;
      $display("FAIL %s @%0t: got out=%b addr=%0d drop=%b, want out=%b addr=%0d drop=%b",
               name, $time, dut_out, cur_addr, pkt_drop, exp_o, exp_a, exp_d);
    end
  endtask

  task automatic drive(input logic pv, input logic [1:0] din, input logic ff, input logic [2:0] fe,
                       input logic [2:0] sr, input logic pd, input logic lpv);
    pkt_valid = pv; data_in = din; fifo_full = ff; fifo_empty = fe;
    soft_reset = sr; parity_done = pd; low_pkt_valid = lpv;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    #12;
    check("reset", O_DEC, 2'd0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    m_ph = PH_IDLE; m_addr = 2'd0; m_wait = 0; m_drop = 1'b0;
  endtask

  task automatic model_step;
    m_drop = 1'b0;
    if (m_ph != PH_IDLE && soft_reset[m_addr]) begin
      m_ph = PH_IDLE;
    end else begin
      case (m_ph)
        PH_IDLE: if (pkt_valid && int'(data_in) < NP) begin
          m_addr = data_in;
          m_wait = 0;
          m_ph   = fifo_empty[data_in] ? PH_HDR : PH_WAIT;
        end
        PH_HDR:   m_ph = PH_PAY;
        PH_PAY:   if (fifo_full) m_ph = PH_FULL; else if (!pkt_valid) m_ph = PH_PAR;
        PH_FULL:  if (!fifo_full) m_ph = PH_AFTER;
        PH_AFTER: if (parity_done) m_ph = PH_IDLE;
                  else if (low_pkt_valid) m_ph = PH_PAR;
                  else m_ph = PH_PAY;
        PH_PAR:   m_ph = PH_CHK;
        PH_CHK:   m_ph = fifo_full ? PH_FULL : PH_IDLE;
        PH_WAIT: begin
          if (fifo_empty[m_addr]) begin
            m_ph = PH_HDR;
          end else begin
            m_wait++;
`ifdef ROUTER_PKT_FSM_TIMEOUT_EN
            if (m_wait == WM) begin
              m_ph   = PH_IDLE;
              m_drop = 1'b1;
            end
`endif
          end
        end
        default: m_ph = PH_IDLE;
      endcase
    end
  endtask

  initial begin
    int n;
    // pv din ff fe sr pd lpv -> outputs after the edge, cur_addr
    tv.push_back(mk(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, O_LFD,  2'd1));
    tv.push_back(mk(1, 2'd1, 0, 3'b111, 3'b000, 0, 0, O_LD,   2'd1));
    tv.push_back(mk(1, 2'd1, 1, 3'b111, 3'b000, 0, 0, O_FULL, 2'd1));
    tv.push_back(mk(1, 2'd1, 1, 3'b111, 3'b000, 0, 0, O_FULL, 2'd1));
    tv.push_back(mk(1, 2'd1, 1, 3'b111, 3'b000, 0, 0, O_FULL, 2'd1));
    tv.push_back(mk(0, 2'd1, 0, 3'b111, 3'b000, 0, 1, O_LAF,  2'd1));
    tv.push_back(mk(0, 2'd1, 0, 3'b111, 3'b000, 0, 1, O_LP,   2'd1));
    tv.push_back(mk(0, 2'd1, 0, 3'b111, 3'b000, 0, 0, O_CPE,  2'd1));
    tv.push_back(mk(0, 2'd1, 0, 3'b111, 3'b000, 0, 0, O_DEC,  2'd1));
    tv.push_back(mk(1, 2'd3, 0, 3'b111, 3'b000, 0, 0, O_DEC,  2'd1));
    tv.push_back(mk(1, 2'd2, 0, 3'b011, 3'b000, 0, 0, O_WAIT, 2'd2));
    tv.push_back(mk(1, 2'd2, 0, 3'b011, 3'b000, 0, 0, O_WAIT, 2'd2));
    tv.push_back(mk(1, 2'd2, 0, 3'b111, 3'b000, 0, 0, O_LFD,  2'd2));
    tv.push_back(mk(1, 2'd2, 0, 3'b111, 3'b000, 0, 0, O_LD,   2'd2));
    tv.push_back(mk(0, 2'd2, 0, 3'b111, 3'b000, 0, 0, O_LP,   2'd2));
    tv.push_back(mk(0, 2'd2, 1, 3'b111, 3'b000, 0, 0, O_CPE,  2'd2));
    tv.push_back(mk(0, 2'd2, 1, 3'b111, 3'b000, 0, 0, O_FULL, 2'd2));
    tv.push_back(mk(0, 2'd2, 0, 3'b111, 3'b000, 0, 0, O_LAF,  2'd2));
    tv.push_back(mk(0, 2'd2, 0, 3'b111, 3'b000, 1, 0, O_DEC,  2'd2));
    tv.push_back(mk(1, 2'd0, 0, 3'b001, 3'b000, 0, 0, O_LFD,  2'd0));
    tv.push_back(mk(1, 2'd0, 0, 3'b001, 3'b000, 0, 0, O_LD,   2'd0));
    tv.push_back(mk(0, 2'd0, 1, 3'b001, 3'b000, 0, 0, O_FULL, 2'd0));
    tv.push_back(mk(1, 2'd0, 0, 3'b001, 3'b000, 0, 0, O_LAF,  2'd0));
    tv.push_back(mk(1, 2'd0, 0, 3'b001, 3'b000, 0, 0, O_LD,   2'd0));
    tv.push_back(mk(1, 2'd0, 0, 3'b001, 3'b010, 0, 0, O_LD,   2'd0));
    tv.push_back(mk(1, 2'd0, 0, 3'b001, 3'b001, 0, 0, O_DEC,  2'd0));
    tv.push_back(mk(0, 2'd0, 0, 3'b001, 3'b001, 0, 0, O_DEC,  2'd0));
    tv.push_back(mk(1, 2'd1, 0, 3'b000, 3'b000, 0, 0, O_WAIT, 2'd1));
    tv.push_back(mk(1, 2'd1, 0, 3'b000, 3'b100, 0, 0, O_WAIT, 2'd1));
    tv.push_back(mk(1, 2'd1, 0, 3'b111, 3'b010, 0, 0, O_DEC,  2'd1));

    do_reset();
    foreach (tv[i]) begin
      drive(tv[i].pv, tv[i].din, tv[i].ff, tv[i].fe, tv[i].sr, tv[i].pd, tv[i].lpv);
      tick();
      check($sformatf("vec%0d", i), tv[i].exp_o, tv[i].exp_a, 1'b0);
    end

    // Async reset in the middle of a payload
    do_reset();
    drive(1, 2'd1, 0, 3'b111, 3'b000, 0, 0);
    tick();
    tick();
    check("pre_async", O_LD, 2'd1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", O_DEC, 2'd0, 1'b0);
    @(negedge clock);
    reset = 1'b0;

`ifdef ROUTER_PKT_FSM_TIMEOUT_EN
    do_reset();
    drive(1, 2'd0, 0, 3'b000, 3'b000, 0, 0);
    tick();
    check("wait_entry", O_WAIT, 2'd0, 1'b0);
    drive(0, 2'd0, 0, 3'b000, 3'b000, 0, 0);
    n = 0;
    while (!detect_add && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != WM) begin
      errors++;
      $display("FAIL timeout_cycles: got %0d wait cycles, want %0d", n, WM);
    end
    check("timeout_drop", O_DEC, 2'd0, 1'b1);
    tick();
    check("drop_one_cycle", O_DEC, 2'd0, 1'b0);

    do_reset();
    drive(1, 2'd2, 0, 3'b000, 3'b000, 0, 0);
    tick();
    drive(0, 2'd0, 0, 3'b000, 3'b000, 0, 0);
    for (int k = 0; k < WM - 1; k++) tick();
    check("pre_tc_wait", O_WAIT, 2'd2, 1'b0);
    drive(0, 2'd0, 0, 3'b100, 3'b000, 0, 0);
    tick();
    check("empty_wins", O_LFD, 2'd2, 1'b0);
`else
    do_reset();
    drive(1, 2'd2, 0, 3'b000, 3'b000, 0, 0);
    tick();
    drive(0, 2'd0, 0, 3'b000, 3'b000, 0, 0);
    for (int k = 0; k < 40; k++) tick();
    check("wait_forever", O_WAIT, 2'd2, 1'b0);
    n = 0;
`endif

    // Random stimulus against the packet-phase model
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      drive($urandom_range(0, 9) < 7,
            2'($urandom_range(0, 3)),
            $urandom_range(0, 9) < 2,
            3'($urandom_range(0, 7)),
            ($urandom_range(0, 29) == 0) ? (3'b001 << $urandom_range(0, 2)) : 3'b000,
            $urandom_range(0, 9) < 2,
            $urandom_range(0, 9) < 3);
      model_step();
      tick();
      check("random", phase_outputs(m_ph), m_addr, m_drop);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
